// File: rtl/m_seq_pkg.sv
// m_seq_pkg: shared constants for the x^20 + x^3 + 1 m-sequence generator and checker
package m_seq_pkg;
  localparam int LFSR_W = 20;
  localparam int TAP_HI = 3;
  localparam int TAP_LO = 0;
  localparam int FILL_LEN = LFSR_W;
  localparam logic [LFSR_W-1:0] ZERO_SEED = '0;
  typedef enum logic [1:0] {
    FILL   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } chk_state_t;
endpackage

// File: rtl/m_seq_lfsr_step.sv
// m_seq_lfsr_step: combinational one-bit advance of the right-shifting m-sequence register
module m_seq_lfsr_step
  import m_seq_pkg::*;
(
  input  logic [LFSR_W-1:0] r,
  output logic              pred,
  output logic [LFSR_W-1:0] r_next
);
  assign pred   = r[TAP_HI] ^ r[TAP_LO];
  assign r_next = {pred, r[LFSR_W-1:1]};
endmodule

// File: rtl/m_seq_checker.sv
// m_seq_checker: self-synchronising m-sequence BER checker; M_CHK_LOSS_EN adds windowed loss-of-lock
module m_seq_checker
  import m_seq_pkg::*;
#(
  parameter int LOCK_CNT = 32,
  parameter int ERR_WIN  = 64,
  parameter int ERR_THR  = 8,
  parameter int CNT_W    = 32
) (
  input  logic             sclk,
  input  logic             rst_n,
  input  logic             din,
  input  logic             din_vld,
  input  logic             clr,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] bit_cnt,
  output logic [1:0]       state
);
  localparam logic [4:0] FILL_LAST = 5'(FILL_LEN - 1);
  localparam logic [7:0] LOCK_LAST = 8'(LOCK_CNT - 1);
  chk_state_t st, st_nx;
  logic [LFSR_W-1:0] r, r_nx, r_pred;
  logic [4:0] fill, fill_nx;
  logic [7:0] match, match_nx;
  logic [CNT_W-1:0] err_nx, bit_nx;
  logic pred, mism, pulse_nx;
`ifdef M_CHK_LOSS_EN
  localparam int WIN_W = $clog2(ERR_WIN + 1);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(ERR_WIN - 1);
  localparam logic [WIN_W-1:0] THR_LAST = WIN_W'(ERR_THR - 1);
  logic [WIN_W-1:0] win_cnt, win_cnt_nx, win_err, win_err_nx;
  logic win_end, loss;
  assign win_end = win_cnt == WIN_LAST;
  assign loss    = mism && win_err == THR_LAST && !clr;
`else
  logic unused_cfg;
  assign unused_cfg = ERR_WIN[0] ^ ERR_THR[0];
`endif
  m_seq_lfsr_step u_step (
    .r      (r),
    .pred   (pred),
    .r_next (r_pred)
  );
  assign mism   = din ^ pred;
  assign state  = st;
  assign locked = st == LOCKED;
  // next-state: fill from the line, then free-run on predictions and score each valid bit
  always_comb begin
    st_nx    = st;
    r_nx     = r;
    fill_nx  = fill;
    match_nx = match;
    pulse_nx = 1'b0;
    err_nx   = err_cnt;
    bit_nx   = bit_cnt;
`ifdef M_CHK_LOSS_EN
    win_cnt_nx = win_cnt;
    win_err_nx = win_err;
`endif
    if (din_vld) begin
      case (st)
        FILL: begin
          r_nx    = {din, r[LFSR_W-1:1]};
          fill_nx = fill + 5'd1;
          if (fill == FILL_LAST) begin
            fill_nx  = '0;
            match_nx = '0;
            st_nx    = (r_nx == ZERO_SEED) ? FILL : VERIFY;
          end
        end
        VERIFY: begin
          r_nx     = r_pred;
          pulse_nx = mism;
          match_nx = mism ? 8'd0 : match + 8'd1;
          st_nx    = mism ? FILL : (match == LOCK_LAST) ? LOCKED : VERIFY;
          fill_nx  = '0;
        end
        LOCKED: begin
          r_nx     = r_pred;
          pulse_nx = mism;
          bit_nx   = (&bit_cnt) ? bit_cnt : bit_cnt + CNT_W'(1);
          err_nx   = (mism && !(&err_cnt)) ? err_cnt + CNT_W'(1) : err_cnt;
`ifdef M_CHK_LOSS_EN
          win_cnt_nx = win_end ? '0 : win_cnt + WIN_W'(1);
          win_err_nx = win_end ? '0 : win_err + WIN_W'(mism);
          if (loss) begin
            st_nx      = FILL;
            fill_nx    = '0;
            win_cnt_nx = '0;
            win_err_nx = '0;
          end
`endif
        end
        default: st_nx = FILL;
      endcase
    end
    if (clr) begin
      err_nx = '0;
      bit_nx = '0;
`ifdef M_CHK_LOSS_EN
      win_cnt_nx = '0;
      win_err_nx = '0;
`endif
    end
  end
  // state and counter registers
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      st        <= FILL;
      r         <= '0;
      fill      <= '0;
      match     <= '0;
      err_pulse <= 1'b0;
      err_cnt   <= '0;
      bit_cnt   <= '0;
`ifdef M_CHK_LOSS_EN
      win_cnt   <= '0;
      win_err   <= '0;
`endif
    end else begin
      st        <= st_nx;
      r         <= r_nx;
      fill      <= fill_nx;
      match     <= match_nx;
      err_pulse <= pulse_nx;
      err_cnt   <= err_nx;
      bit_cnt   <= bit_nx;
`ifdef M_CHK_LOSS_EN
      win_cnt   <= win_cnt_nx;
      win_err   <= win_err_nx;
`endif
    end
  end
endmodule

// File: tb/tb_m_seq_checker.sv
// tb_m_seq_checker: randomized bench comparing m_seq_checker with a bit-history reference model
module tb_m_seq_checker;
  localparam int LOCK_CNT = 32;
  localparam int ERR_WIN  = 64;
  localparam int ERR_THR  = 8;
  localparam int CNT_W    = 32;
  localparam longint MAXC = (longint'(1) << CNT_W) - 1;
`ifdef M_CHK_LOSS_EN
  localparam bit LOSS = 1'b1;
`else
  localparam bit LOSS = 1'b0;
`endif
  logic sclk = 1'b0;
  logic rst_n = 1'b0;
  logic din = 1'b0;
  logic din_vld = 1'b0;
  logic clr = 1'b0;
  logic locked, err_pulse;
  logic [CNT_W-1:0] err_cnt, bit_cnt;
  logic [1:0] state;
  int checks = 0;
  int failures = 0;
  m_seq_checker #(
    .LOCK_CNT (LOCK_CNT),
    .ERR_WIN  (ERR_WIN),
    .ERR_THR  (ERR_THR),
    .CNT_W    (CNT_W)
  ) dut (
    .sclk      (sclk),
    .rst_n     (rst_n),
    .din       (din),
    .din_vld   (din_vld),
    .clr       (clr),
    .locked    (locked),
    .err_pulse (err_pulse),
    .err_cnt   (err_cnt),
    .bit_cnt   (bit_cnt),
    .state     (state)
  );
  always #5 sclk = ~sclk;
  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  // reference model: the checker sees the bit sequence, predicts b[n] = b[n-20] ^ b[n-17]
  bit hist[$];
  int mode = 0, fcnt = 0, mcnt = 0, wcnt = 0, werr = 0, vseen = 0;
  longint ecnt = 0, bcnt = 0;
  bit epulse = 1'b0, p, e, nz;
  always @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      hist.delete();
      mode = 0; fcnt = 0; mcnt = 0; wcnt = 0; werr = 0;
      ecnt = 0; bcnt = 0; epulse = 1'b0;
    end else begin
      epulse = 1'b0;
      if (din_vld) begin
        vseen++;
        if (mode == 0) begin
          hist.push_back(din);
          if (hist.size() > 20) void'(hist.pop_front());
          fcnt++;
          if (fcnt == 20) begin
            fcnt = 0;
            nz = 1'b0;
            foreach (hist[i]) nz |= hist[i];
            if (nz) begin mode = 1; mcnt = 0; end
          end
        end else begin
          p = hist[0] ^ hist[3];
          e = din != p;
          hist.push_back(p);
          void'(hist.pop_front());
          epulse = e;
          if (mode == 1) begin
            if (e) begin mode = 0; fcnt = 0; end
            else begin
              mcnt++;
              if (mcnt == LOCK_CNT) mode = 2;
            end
          end else if (!clr) begin
            if (bcnt < MAXC) bcnt++;
            if (e && ecnt < MAXC) ecnt++;
            if (LOSS) begin
              wcnt++;
              werr += int'(e);
              if (werr == ERR_THR) begin mode = 0; fcnt = 0; wcnt = 0; werr = 0; end
              else if (wcnt == ERR_WIN) begin wcnt = 0; werr = 0; end
            end
          end
        end
      end
      if (clr) begin ecnt = 0; bcnt = 0; wcnt = 0; werr = 0; end
    end
  end
  // per-cycle comparison against the model, plus lock/pulse bookkeeping for literal checks
  bit prev_locked = 1'b0;
  int lock_v = -1;
  int pulses = 0;
  always @(negedge sclk) begin
    if (rst_n) begin
      chk("state", longint'(state), longint'(mode));
      chk("locked", longint'(locked), longint'(mode == 2));
      chk("err_pulse", longint'(err_pulse), longint'(epulse));
      chk("err_cnt", longint'(err_cnt), ecnt);
      chk("bit_cnt", longint'(bit_cnt), bcnt);
      if (locked && !prev_locked) lock_v = vseen;
      pulses += int'(err_pulse);
      prev_locked = locked;
    end
  end
  logic [19:0] g = '1;
  task automatic send(input bit v, input bit flip, input bit c);
    @(negedge sclk);
    din_vld = v;
    clr = c;
    din = v ? (g[0] ^ flip) : 1'($urandom);
    if (v) g = {g[3] ^ g[0], g[19:1]};
  endtask
  task automatic idle();
    @(negedge sclk);
    din_vld = 1'b0;
    clr = 1'b0;
    din = 1'b0;
  endtask
  task automatic do_reset();
    @(negedge sclk);
    #2 rst_n = 1'b0;
    din_vld = 1'b0;
    clr = 1'b0;
    @(negedge sclk);
    #2 rst_n = 1'b1;
  endtask
  initial begin
    int base, p0;
    bit noisy;
    do_reset();
    idle();
    chk("rst_state", longint'(state), 0);
    chk("rst_locked", longint'(locked), 0);
    chk("rst_err_cnt", longint'(err_cnt), 0);
    chk("rst_bit_cnt", longint'(bit_cnt), 0);
    g = '1;
    base = vseen;
    repeat (200) send(1'b1, 1'b0, 1'b0);
    idle();
    chk("first_lock_bit", longint'(lock_v - base), 52);
    chk("stream_err_cnt", longint'(err_cnt), 0);
    chk("stream_bit_cnt", longint'(bit_cnt), 148);
    chk("stream_locked", longint'(locked), 1);
    send(1'b0, 1'b0, 1'b1);
    idle();
    chk("clr_err_cnt", longint'(err_cnt), 0);
    chk("clr_bit_cnt", longint'(bit_cnt), 0);
    p0 = pulses;
    for (int i = 0; i < 100; i++) send(1'b1, i == 10 || i == 40 || i == 70, 1'b0);
    idle();
    chk("iso_err_cnt", longint'(err_cnt), 3);
    chk("iso_pulses", longint'(pulses - p0), 3);
    chk("iso_locked", longint'(locked), 1);
    chk("iso_bit_cnt", longint'(bit_cnt), 100);
    send(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 16; i++) send(1'b1, i % 2 == 1, 1'b0);
    idle();
    chk("burst_err_cnt", longint'(err_cnt), 8);
    chk("burst_bit_cnt", longint'(bit_cnt), 16);
`ifdef M_CHK_LOSS_EN
    chk("burst_locked", longint'(locked), 0);
    chk("burst_state", longint'(state), 0);
    base = vseen;
    repeat (60) send(1'b1, 1'b0, 1'b0);
    idle();
    chk("relock_bit", longint'(lock_v - base), 52);
    chk("relock_err_cnt", longint'(err_cnt), 8);
    chk("relock_bit_cnt", longint'(bit_cnt), 24);
`else
    chk("burst_locked", longint'(locked), 1);
    chk("burst_state", longint'(state), 2);
`endif
    do_reset();
    repeat (20) begin
      @(negedge sclk);
      din_vld = 1'b1;
      din = 1'b0;
      clr = 1'b0;
    end
    idle();
    chk("zero_seed_state", longint'(state), 0);
    g = 20'h5A5A5;
    base = vseen;
    repeat (60) send(1'b1, 1'b0, 1'b0);
    idle();
    chk("zero_seed_lock_bit", longint'(lock_v - base), 52);
    do_reset();
    g = 20'hABCDE;
    base = vseen;
    for (int i = 0; i < 120; i++) send(i % 2 == 0, 1'b0, 1'b0);
    chk("toggle_lock_bit", longint'(lock_v - base), 52);
    send(1'b1, 1'b0, 1'b1);
    idle();
    chk("midclr_err_cnt", longint'(err_cnt), 0);
    chk("midclr_bit_cnt", longint'(bit_cnt), 0);
    repeat (10) send(1'b1, 1'b0, 1'b0);
    idle();
    chk("resume_bit_cnt", longint'(bit_cnt), 10);
    do_reset();
    g = 20'($urandom) | 20'h1;
    for (int i = 0; i < 6000; i++) begin
      if ($urandom_range(0, 1499) == 0) do_reset();
      noisy = (i / 400) % 3 == 2;
      send($urandom_range(0, 3) != 0,
           noisy ? $urandom_range(0, 4) == 0 : $urandom_range(0, 59) == 0,
           $urandom_range(0, 199) == 0);
    end
    idle();
    idle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/m_seq_checker.md
Name: m_seq_checker

Overview:
- Receive-side checker for the 20-bit m-sequence stream (recurrence x^20 + x^3 + 1). The transmitted bit each cycle is generator state bit [0]; the generator shifts right and loads new [19] = s[3] ^ s[0].
- Self-synchronises a local copy of the LFSR from the incoming serial bits, declares lock, then counts bit errors.
- Sits at the far end of a link or loopback, opposite the m-sequence generator, for BER measurement.

Parameters:
LOCK_CNT, 32, consecutive correct predicted bits in VERIFY needed to enter LOCKED (range 1..255)
ERR_WIN, 64, valid-bit window length for loss-of-lock evaluation (range 2..1023)
ERR_THR, 8, errors within one window that force loss of lock (range 1..ERR_WIN)
CNT_W, 32, width of the bit and error counters

Ports:
sclk  in  1  clock, rising edge
rst_n  in  1  asynchronous reset, active-low
din  in  1  received serial bit
din_vld  in  1  din qualifier; all state advances only when high
clr  in  1  synchronous clear of err_cnt, bit_cnt and the window counters; state machine unaffected
locked  out  1  high while in LOCKED
err_pulse  out  1  one-cycle pulse, registered, for each mismatched bit in VERIFY or LOCKED
err_cnt  out  CNT_W  errors counted in LOCKED, saturating at all-ones
bit_cnt  out  CNT_W  valid bits checked in LOCKED, saturating at all-ones
state  out  2  0=FILL, 1=VERIFY, 2=LOCKED

Behaviour:
- Clock and reset: one clock, sclk; reset asynchronous active-low, rst_n. On reset: state=FILL, local register r=0, fill counter=0, locked=0, err_pulse=0, err_cnt=0, bit_cnt=0.
- Predicted bit: p = r[3] ^ r[0].
- FILL:
  - Each valid bit: r[18:0] <= r[19:1]; r[19] <= din; increment fill counter.
  - After the 20th valid bit r equals the transmitter state.
  - If r is all-zero at that point, restart FILL (counter cleared). Otherwise go to VERIFY with the match counter at 0.
- VERIFY:
  - Each valid bit: compare din with p; r shifts in p, not din.
  - Match: increment match counter. When it reaches LOCK_CNT, go to LOCKED.
  - Mismatch: err_pulse, clear counters, return to FILL. The error is not added to err_cnt.
- LOCKED:
  - Each valid bit: r shifts in p; bit_cnt += 1; on mismatch, err_pulse and err_cnt += 1.
  - Window counters track errors per ERR_WIN valid bits. At the window end both reset.
- Loss of lock: if ERR_THR errors are reached inside a window, on that same bit go to FILL next cycle. err_cnt and bit_cnt hold; locked drops.
- Output timing: locked, state and err_pulse are registered and update the cycle after the qualifying valid bit. With back-to-back valid bits from reset, locked rises the cycle after valid bit number 20 + LOCK_CNT.
- din_vld low: no state, counter or r change; err_pulse=0.
- clr together with a valid bit: clr wins; counters become 0 and that bit is not counted.
- Saturation: counters stop at 2^CNT_W-1 and do not wrap.
- Reset mid-operation: immediate return to reset values, regardless of state.

Optional Feature:
M_CHK_LOSS_EN
- Defined: loss-of-lock logic and window counters are present, as described above.
- Undefined: window logic is removed and LOCKED is sticky. Only rst_n returns to FILL; clr clears counters only.

Decomposition:
- Shared package: LFSR width constant (20), tap positions (3, 0), state encoding constants (FILL, VERIFY, LOCKED), and the all-zero illegal-seed constant. The generator also uses these.
- One natural sub-module, m_seq_lfsr_step: a combinational next-state/predicted-bit function of r, reusable by the generator.

Test Plan:
- Reset generator model to all-ones, stream 200 bits with din_vld=1 -> locked rises cycle after bit 52; err_cnt=0, bit_cnt=148 after the stream.
- Locked stream, invert 3 isolated bits (each >20 bits apart) -> three err_pulse cycles; err_cnt=3; locked stays 1. Confirms no error propagation.
- Locked, invert 8 bits inside one 64-bit window (macro defined) -> locked falls cycle after 8th error; state=FILL; relock after 52 further clean bits; err_cnt stays 8.
- Same as above with macro undefined -> locked stays 1; err_cnt=8.
- Feed 20 zeros then the valid stream -> no VERIFY entry on the zero seed; lock achieved after the next 52 valid bits.
- din_vld toggling 1/0 every cycle -> lock after 52 valid bits (104 cycles). Assert clr mid-stream -> err_cnt=bit_cnt=0 next cycle, counting resumes.
